// File: rtl/roll_sched_pkg.sv
// Shared types and constants for the roll_scheduler rotate engine.
// Optional barrel rotate is selected by defining ROLL_SCHED_FAST_ROT_EN.
package roll_sched_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REV_IN  = 3'd1,
        ROT     = 3'd2,
        REV_OUT = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arb2
    import roll_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] grant_c_o,
    output logic       grant_id_c_o
);

    logic last_q, last_d;

    // Single valid wins outright; on a tie the side not granted last wins.
    always_comb begin
        grant_id_c_o = ID_A;
        grant_c_o    = 2'b00;
        last_d       = last_q;
        case (valid_i)
            2'b10:   grant_id_c_o = ID_B;
            2'b11:   grant_id_c_o = (last_q == ID_A) ? ID_B : ID_A;
            default: grant_id_c_o = ID_A;
        endcase
        if (en_i && (valid_i != 2'b00)) begin
            grant_c_o = (grant_id_c_o == ID_B) ? 2'b10 : 2'b01;
            last_d    = grant_id_c_o;
        end
    end

    // Reset to "B granted last" so A is favoured first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= ID_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/roll_scheduler.sv
// Two-requester rotate engine: left rotate is done as reverse, rotate right, reverse.
// Define ROLL_SCHED_FAST_ROT_EN for a single-cycle barrel rotate instead of the serial one.
module roll_scheduler
    import roll_sched_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reqValidA,
    output logic                       reqReadyA,
    input  logic [WIDTH-1:0]           reqDataA,
    input  logic [$clog2(WIDTH)-1:0]   reqAmtA,
    input  logic                       reqDirA,
    input  logic                       reqValidB,
    output logic                       reqReadyB,
    input  logic [WIDTH-1:0]           reqDataB,
    input  logic [$clog2(WIDTH)-1:0]   reqAmtB,
    input  logic                       reqDirB,
    output logic                       respValid,
    input  logic                       respReady,
    output logic [WIDTH-1:0]           respData,
    output logic                       respId
);

    localparam int unsigned AMT_W = $clog2(WIDTH);

    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("roll_scheduler: WIDTH must be a power of two >= 4");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               id_q, id_d;
    logic               resp_valid_q, resp_valid_d;

    logic [1:0]         grant;
    logic               grant_id;
    logic               arb_en;
    logic               accept;
    logic [WIDTH-1:0]   sel_data;
    logic [AMT_W-1:0]   sel_amt;
    logic               sel_dir;
    logic [WIDTH-1:0]   rev_w;
    logic [WIDTH-1:0]   rot_w;
    logic [AMT_W-1:0]   rot_amt_w;
    logic               rot_last;

    assign arb_en = (state_q == IDLE) && rst_n;

    rr_arb2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      ({reqValidB, reqValidA}),
        .en_i         (arb_en),
        .grant_c_o    (grant),
        .grant_id_c_o (grant_id)
    );

    assign reqReadyA = grant[0];
    assign reqReadyB = grant[1];
    assign accept    = |grant;

    assign sel_data = (grant_id == ID_B) ? reqDataB : reqDataA;
    assign sel_amt  = (grant_id == ID_B) ? reqAmtB  : reqAmtA;
    assign sel_dir  = (grant_id == ID_B) ? reqDirB  : reqDirA;

`ifdef ROLL_SCHED_FAST_ROT_EN
    assign rot_amt_w = cnt_q;
    assign rot_last  = 1'b1;
`else
    assign rot_amt_w = AMT_W'(1);
    assign rot_last  = (cnt_q == AMT_W'(1));
`endif

    // Bit reverse and rotate-right views of the working register.
    always_comb begin
        logic [AMT_W-1:0] idx;
        rev_w = '0;
        rot_w = '0;
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_w[i] = work_q[WIDTH-1-i];
            idx      = AMT_W'(i) + rot_amt_w;
            rot_w[i] = work_q[idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d = sel_data;
                    cnt_d  = sel_amt;
                    dir_d  = sel_dir;
                    id_d   = grant_id;
                    if (sel_dir == DIR_LEFT) begin
                        state_d = REV_IN;
                    end else if (sel_amt != '0) begin
                        state_d = ROT;
                    end else begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            REV_IN: begin
                work_d  = rev_w;
                state_d = (cnt_q != '0) ? ROT : REV_OUT;
            end
            ROT: begin
                work_d = rot_w;
`ifndef ROLL_SCHED_FAST_ROT_EN
                cnt_d  = cnt_q - AMT_W'(1);
`endif
                if (rot_last) begin
                    if (dir_q == DIR_LEFT) begin
                        state_d = REV_OUT;
                    end else begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            REV_OUT: begin
                work_d       = rev_w;
                state_d      = DONE;
                resp_valid_d = 1'b1;
            end
            DONE: begin
                if (respReady) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            work_q       <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_RIGHT;
            id_q         <= ID_A;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign respValid = resp_valid_q;
    assign respData  = work_q;
    assign respId    = id_q;

endmodule

// File: doc/roll_scheduler.md
ROLL_SCHEDULER -- requirements
Module: roll_scheduler

Interface
REQ-001 Parameter: WIDTH, 16, datapath width; SHALL be a power of two ≥ 4; AMT_W = log2(WIDTH) derived, not overridable.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- reqValidA  in  1  requester A has a job
- reqReadyA  out  1  job A accepted this edge
- reqDataA  in  WIDTH  operand A
- reqAmtA  in  AMT_W  rotate amount A
- reqDirA  in  1  0 = rotate right, 1 = rotate left (A)
- reqValidB / reqReadyB / reqDataB / reqAmtB / reqDirB  same as A, for requester B
- respValid  out  1  result available
- respReady  in  1  consumer takes result
- respData  out  WIDTH  rotated result
- respId  out  1  0 = A, 1 = B

Function
REQ-003 Arbitration SHALL be two-way round robin: if exactly one request is valid it wins; if both are valid, the requester not granted last wins. After reset, A is favoured.
REQ-004 reqReadyX SHALL be high only in IDLE, and only for the winning valid requester; it SHALL be combinational from the valid inputs and the state.
REQ-005 Accept = reqValidX && reqReadyX at a rising edge. Data, amount, direction and id SHALL be captured on that edge. Later changes to the request inputs SHALL be ignored.
REQ-006 FSM states SHALL be IDLE, REV_IN, ROT, REV_OUT and DONE.
REQ-007 Transitions on accept: dir=1 → REV_IN; dir=0 and amt≠0 → ROT; dir=0 and amt=0 → DONE.
REQ-008 REV_IN SHALL bit-reverse the working register (bit i → bit WIDTH-1-i) for one cycle, then go to ROT if amt≠0, else REV_OUT.
REQ-009 ROT SHALL rotate the working register right by one bit per cycle for amt cycles, using a down-counter loaded with amt. It then goes to REV_OUT if dir=1, else DONE.
REQ-010 REV_OUT SHALL bit-reverse for one cycle, then go to DONE. Reverse, rotate right, reverse yields rotate left.
REQ-011 DONE SHALL assert respValid. respData and respId SHALL stay stable until respReady; on respValid && respReady the FSM goes to IDLE.
REQ-012 Latency: DONE SHALL be entered N edges after the accepting edge, with N = amt + 2·dir. No new accept SHALL occur before the return to IDLE.
REQ-013 Boundaries:
- amt=0 with dir=1 SHALL return the operand unchanged after 2 cycles.
- amt = WIDTH-1 SHALL be legal.
- A request deasserting before it is accepted SHALL be lost silently.
- respReady held low SHALL stall indefinitely in DONE.

Reset
REQ-014 While rst_n=0 at an edge:
- state → IDLE, and any job in progress is discarded.
- respValid=0, respData=0, respId=0, counter=0.
- The round-robin pointer favours A.
- reqReadyA and reqReadyB SHALL be 0 during reset.

Configuration
REQ-015 Macro ROLL_SCHED_FAST_ROT_EN selects the rotate implementation:
- Defined: ROT SHALL rotate by the full amt in one cycle (barrel) and N = (amt≠0) + 2·dir.
- Undefined: serial rotate per REQ-009.
- Function results SHALL be identical in both modes.

Structure
REQ-016 Package roll_sched_pkg SHALL hold:
- the state enum
- the WIDTH default
- the direction encoding (DIR_RIGHT, DIR_LEFT)
- the requester id constants (ID_A, ID_B)
REQ-017 Round-robin arbitration SHALL be in sub-module rr_arb2: inputs valid pair, enable, clk, rst_n; outputs grant pair and grant id; pointer updated on enabled grant.

Verification
REQ-018 A only: data 0x1234, amt 4, dir 0 → respData 0x4123, respId 0, DONE 4 edges after accept (1 edge with FAST_ROT).
REQ-019 B only: data 0x8001, amt 4, dir 1 → respData 0x0018, respId 1, N=6 (3 with FAST_ROT).
REQ-020 A and B both valid continuously, each with data 0x0001, amt 1, dir 0 → accepts alternate A, B, A, B; each respData 0x8000.
REQ-021 dir 1, amt 0, data 0xA5C3 → respData 0xA5C3 after 2 edges; then respReady low 5 cycles → respValid and respData hold.
REQ-022 rst_n low mid-ROT on data 0xFFFF, amt 15 → next cycle IDLE, respValid 0, respData 0; a fresh request is accepted and completes correctly.
